// File: rtl/rotary_value_tracker.sv
// rtl/rotary_value_tracker.sv - bounded, velocity-accelerated setting value driven by rotary detents
//
// Turns single-cycle detent pulses from the rotary decoder into a setting that
// either saturates or wraps at its bounds. A detent in the same direction as
// the previous one, arriving within ACCEL_WINDOW cycles of it, moves the value
// by ACCEL_STEP instead of 1. Every change is published to the display path
// over a valid/ready channel. Changes that arrive while an offer is pending
// are coalesced, so only the newest value follows the pending one.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   inc_pulse   one-cycle clockwise detent
//   dec_pulse   one-cycle counter-clockwise detent
//   load        one-cycle strobe that overwrites the value
//   load_value  value applied on load, clamped to [MIN_VAL, MAX_VAL]
//   value       current setting, registered
//   upd_valid   an update is offered to the consumer
//   upd_data    value carried by the offered update, stable while offered
//   upd_ready   consumer accepts the offered update

module rotary_value_tracker #(
    parameter int WIDTH        = 8,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 100,
    parameter int INIT_VAL     = 50,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 2_000_000,
    parameter int ACCEL_STEP   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_pulse,
    input  logic             dec_pulse,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             upd_valid,
    output logic [WIDTH-1:0] upd_data,
    input  logic             upd_ready
);

    // Arithmetic is carried one bit wider than the value so that neither
    // value+step nor the bound comparisons can overflow.
    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   FAST_X = (WIDTH+1)'(ACCEL_STEP);
    localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);
    localparam logic [31:0]      WINDOW = 32'(ACCEL_WINDOW);
    localparam logic             WRAP_EN = (WRAP != 0);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Value and acceleration state
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic [31:0]      timer_q;
    logic [31:0]      timer_d;
    dir_t             last_dir_q;
    dir_t             last_dir_d;

    // Update channel state
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] upd_data_q;
    logic [WIDTH-1:0] upd_data_d;
    logic             dirty_q;
    logic             dirty_d;
    logic             dirty_clr;

    // Detent decode and step arithmetic
    logic             detent;
    dir_t             dir_evt;
    logic             fast;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   val_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   diff_x;
    logic             inc_over;
    logic             dec_under;
    logic [WIDTH-1:0] inc_res;
    logic [WIDTH-1:0] dec_res;
    logic [WIDTH:0]   load_x;
    logic [WIDTH-1:0] load_clamped;

    // Both pulses high in one cycle is treated as no detent at all.
    assign detent  = inc_pulse ^ dec_pulse;
    assign dir_evt = inc_pulse ? DIR_UP : DIR_DOWN;

    // The timer holds at WINDOW once it gets there, so "timer < WINDOW" means
    // the previous detent was recent enough. Load and reset park it at WINDOW.
    assign fast = (dir_evt == last_dir_q) && (timer_q < WINDOW);
    assign step = fast ? FAST_X : ONE_X;

    assign val_x  = {1'b0, value_q};
    assign sum_x  = val_x + step;
    assign diff_x = val_x - step;

    assign inc_over = (sum_x > MAX_X);
    // When step exceeds the value, diff_x has wrapped around, so the first
    // term catches a true underflow below zero.
    assign dec_under = (step > val_x) || (diff_x < MIN_X);

    // In wrap mode an overshoot lands exactly on the opposite bound,
    // independent of how far past the bound the step would have gone.
    assign inc_res = inc_over  ? (WRAP_EN ? MIN_V : MAX_V) : sum_x[WIDTH-1:0];
    assign dec_res = dec_under ? (WRAP_EN ? MAX_V : MIN_V) : diff_x[WIDTH-1:0];

    assign load_x       = {1'b0, load_value};
    assign load_clamped = (load_x < MIN_X) ? MIN_V :
                          (load_x > MAX_X) ? MAX_V : load_value;

    // Value / acceleration next state; load wins over any detent.
    always_comb begin
        value_d    = value_q;
        last_dir_d = last_dir_q;
        timer_d    = (timer_q < WINDOW) ? (timer_q + 32'd1) : WINDOW;

        if (load) begin
            value_d    = load_clamped;
            timer_d    = WINDOW;
            last_dir_d = DIR_NONE;
        end else if (detent) begin
            value_d    = inc_pulse ? inc_res : dec_res;
            timer_d    = 32'd0;
            last_dir_d = dir_evt;
        end
    end

    // Update channel FSM. Only the newest value is ever held: dirty is a
    // single flag, so intermediate values seen during an offer are dropped.
    always_comb begin
        state_d    = state_q;
        upd_data_d = upd_data_q;
        dirty_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dirty_q) begin
                    upd_data_d = value_q;
                    dirty_clr  = 1'b1;
                    state_d    = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (upd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // While dirty is clear the value always equals the last value handed to
    // the channel, so an actual change of value is exactly the condition for
    // a new update. A change landing on the same edge that the channel
    // captures the previous value must survive the clear, hence set wins.
    always_comb begin
        dirty_d = dirty_q & ~dirty_clr;
        if (value_d != value_q) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= INIT_V;
            timer_q    <= WINDOW;
            last_dir_q <= DIR_NONE;
            state_q    <= ST_IDLE;
            upd_data_q <= INIT_V;
            dirty_q    <= 1'b0;
        end else begin
            value_q    <= value_d;
            timer_q    <= timer_d;
            last_dir_q <= last_dir_d;
            state_q    <= state_d;
            upd_data_q <= upd_data_d;
            dirty_q    <= dirty_d;
        end
    end

    assign value     = value_q;
    assign upd_data  = upd_data_q;
    assign upd_valid = (state_q == ST_OFFER);

endmodule

// File: tb/tb_rotary_value_tracker.sv
// tb/tb_rotary_value_tracker.sv - self-checking bench for rotary_value_tracker
module tb_rotary_value_tracker;

    localparam int WIN   = 16;
    localparam int ACC   = 5;
    localparam int MINV  = 0;
    localparam int MAXV  = 100;
    localparam int INITV = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       load;
    logic [7:0] load_value;
    logic       upd_ready;

    logic [7:0] value_s;
    logic [7:0] data_s;
    logic       valid_s;
    logic [7:0] value_w;
    logic [7:0] data_w;
    logic       valid_w;

    rotary_value_tracker #(
        .WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INITV),
        .WRAP(0), .ACCEL_WINDOW(WIN), .ACCEL_STEP(ACC)
    ) dut_sat (
        .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .load(load), .load_value(load_value), .value(value_s),
        .upd_valid(valid_s), .upd_data(data_s), .upd_ready(upd_ready)
    );

    rotary_value_tracker #(
        .WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INITV),
        .WRAP(1), .ACCEL_WINDOW(WIN), .ACCEL_STEP(ACC)
    ) dut_wrap (
        .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .load(load), .load_value(load_value), .value(value_w),
        .upd_valid(valid_w), .upd_data(data_w), .upd_ready(upd_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: index 0 = saturating instance, 1 = wrapping instance.
    int m_val  [2];
    int m_data [2];
    bit m_valid[2];
    bit m_pend [2];
    int m_dir;        // 0 none, +1 up, -1 down
    int m_last_cyc;   // edge index of the last accepted detent
    int cyc;
    int hs     [2];   // handshakes observed

    function automatic int clampv(input int x);
        if (x < MINV) return MINV;
        if (x > MAXV) return MAXV;
        return x;
    endfunction

    function automatic int move(input int wrap, input int v, input int dir, input int st);
        int r;
        r = v + dir * st;
        if (r > MAXV) r = (wrap != 0) ? MINV : MAXV;
        if (r < MINV) r = (wrap != 0) ? MAXV : MINV;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k]   = INITV;
            m_data[k]  = INITV;
            m_valid[k] = 1'b0;
            m_pend[k]  = 1'b0;
        end
        m_dir = 0;
    endtask

    task automatic model_edge(input bit i, input bit d, input bit ld, input int lv, input bit rdy);
        int nv;
        int dir;
        int st;
        for (int k = 0; k < 2; k++) begin
            if (m_valid[k]) begin
                if (rdy) m_valid[k] = 1'b0;
            end else if (m_pend[k]) begin
                m_valid[k] = 1'b1;
                m_data[k]  = m_val[k];
                m_pend[k]  = 1'b0;
            end
        end
        if (ld) begin
            nv = clampv(lv);
            for (int k = 0; k < 2; k++) begin
                if (nv != m_val[k]) m_pend[k] = 1'b1;
                m_val[k] = nv;
            end
            m_dir = 0;
        end else if (i != d) begin
            dir = i ? 1 : -1;
            st  = (dir == m_dir && (cyc - m_last_cyc) <= WIN) ? ACC : 1;
            for (int k = 0; k < 2; k++) begin
                nv = move(k, m_val[k], dir, st);
                if (nv != m_val[k]) m_pend[k] = 1'b1;
                m_val[k] = nv;
            end
            m_dir      = dir;
            m_last_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic compare_all();
        check_eq("sat.value",  int'(value_s), m_val[0]);
        check_eq("sat.valid",  int'(valid_s), int'(m_valid[0]));
        check_eq("sat.data",   int'(data_s),  m_data[0]);
        check_eq("wrap.value", int'(value_w), m_val[1]);
        check_eq("wrap.valid", int'(valid_w), int'(m_valid[1]));
        check_eq("wrap.data",  int'(data_w),  m_data[1]);
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit i, input bit d, input bit ld, input int lv);
        inc_pulse  = i;
        dec_pulse  = d;
        load       = ld;
        load_value = 8'(lv);
        if (valid_s && upd_ready) hs[0]++;
        if (valid_w && upd_ready) hs[1]++;
        model_edge(i, d, ld, lv, upd_ready);
        @(posedge clk);
        #1;
        compare_all();
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        load      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b0, 0);
    endtask

    int hs0_base;
    int hs1_base;
    int r;
    int bias;
    int lv;
    bit ri;
    bit rd;
    bit rl;

    initial begin
        rst        = 1'b1;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        upd_ready  = 1'b1;
        cyc        = 0;
        m_last_cyc = 0;
        hs[0]      = 0;
        hs[1]      = 0;
        model_reset();

        #12;
        check_eq("reset.value", int'(value_s), INITV);
        check_eq("reset.valid", int'(valid_s), 0);
        check_eq("reset.data",  int'(data_s),  INITV);
        @(negedge clk);
        rst = 1'b0;

        // Single increment and its update handshake
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("inc.value", int'(value_s), 51);
        check_eq("inc.valid_n1", int'(valid_s), 0);
        tick(1'b0, 1'b0, 1'b0, 0);
        check_eq("inc.valid_n2", int'(valid_s), 1);
        check_eq("inc.data", int'(data_s), 51);
        tick(1'b0, 1'b0, 1'b0, 0);
        check_eq("inc.accepted", int'(valid_s), 0);
        idle(20);

        // Saturate vs wrap from 99
        hs0_base = hs[0];
        hs1_base = hs[1];
        tick(1'b0, 1'b0, 1'b1, 99);
        idle(30);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("bound1.sat", int'(value_s), 100);
        check_eq("bound1.wrap", int'(value_w), 100);
        idle(30);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("bound2.sat", int'(value_s), 100);
        check_eq("bound2.wrap", int'(value_w), 0);
        idle(30);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("bound3.sat", int'(value_s), 100);
        check_eq("bound3.wrap", int'(value_w), 1);
        idle(30);
        check_eq("bound.sat_updates", hs[0] - hs0_base, 2);
        check_eq("bound.wrap_updates", hs[1] - hs1_base, 4);

        // Acceleration and its window boundary
        tick(1'b0, 1'b0, 1'b1, 50);
        idle(30);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("accel.first", int'(value_s), 51);
        idle(9);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("accel.fast", int'(value_s), 56);
        idle(WIN);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("accel.expired", int'(value_s), 57);
        idle(WIN - 1);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("accel.edge_of_window", int'(value_s), 62);
        idle(30);

        // Reversal forces step 1
        tick(1'b0, 1'b0, 1'b1, 50);
        idle(30);
        tick(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        tick(1'b0, 1'b1, 1'b0, 0);
        check_eq("reverse.value", int'(value_s), 50);
        idle(30);

        // Both pulses: ignored, acceleration state kept
        tick(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        tick(1'b1, 1'b1, 1'b0, 0);
        check_eq("both.value", int'(value_s), 51);
        idle(2);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_eq("both.accel_kept", int'(value_s), 56);
        idle(30);

        // Load priority and clamping
        tick(1'b1, 1'b0, 1'b1, 10);
        check_eq("load_prio.value", int'(value_s), 10);
        idle(5);
        tick(1'b0, 1'b0, 1'b1, 200);
        check_eq("load_clamp.value", int'(value_s), 100);
        idle(30);

        // Backpressure coalescing
        tick(1'b0, 1'b0, 1'b1, 50);
        idle(30);
        upd_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            tick(1'b1, 1'b0, 1'b0, 0);
            idle(29);
        end
        check_eq("coalesce.held_valid", int'(valid_s), 1);
        check_eq("coalesce.held_data", int'(data_s), 51);
        check_eq("coalesce.value", int'(value_s), 54);
        upd_ready = 1'b1;
        idle(2);
        check_eq("coalesce.next_valid", int'(valid_s), 1);
        check_eq("coalesce.next_data", int'(data_s), 54);
        idle(10);

        // Reset in the middle of an offer
        upd_ready = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 70);
        idle(2);
        check_eq("midreset.pre_valid", int'(valid_s), 1);
        check_eq("midreset.pre_value", int'(value_s), 70);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midreset.value", int'(value_s), INITV);
        check_eq("midreset.valid", int'(valid_s), 0);
        check_eq("midreset.data", int'(data_s), INITV);
        check_eq("midreset.wrap_valid", int'(valid_w), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        upd_ready = 1'b1;
        idle(6);
        check_eq("midreset.quiet", int'(valid_s), 0);
        tick(1'b0, 1'b1, 1'b0, 0);
        idle(10);

        // Randomized traffic with direction-biased phases
        for (int t = 0; t < 3000; t++) begin
            r = int'($urandom_range(0, 99));
            upd_ready = ($urandom_range(0, 3) != 0);
            case ((t / 400) % 3)
                0:       bias = 80;
                1:       bias = 20;
                default: bias = 50;
            endcase
            ri = 1'b0;
            rd = 1'b0;
            rl = 1'b0;
            lv = 0;
            if (r < 3) begin
                rl = 1'b1;
                lv = int'($urandom_range(0, 255));
                ri = ($urandom_range(0, 1) != 0);
            end else if (r < 18) begin
                if (int'($urandom_range(0, 99)) < bias) ri = 1'b1;
                else rd = 1'b1;
            end else if (r < 20) begin
                ri = 1'b1;
                rd = 1'b1;
            end
            tick(ri, rd, rl, lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
